// File: rtl/seq_mul_ctrl.sv
// seq_mul_ctrl: shift-add unsigned multiplier controller driving an external WIDTH-bit adder
module seq_mul_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               iClk,
  input  logic               iRstN,
  input  logic               iValid,
  output logic               oReady,
  input  logic [WIDTH-1:0]   iDataA,
  input  logic [WIDTH-1:0]   iDataB,
  output logic [WIDTH-1:0]   oAddA,
  output logic [WIDTH-1:0]   oAddB,
  output logic               oAddCin,
  input  logic [WIDTH-1:0]   iAddSum,
  input  logic               iAddCout,
  output logic               oValid,
  input  logic               iReady,
  output logic [2*WIDTH-1:0] oProduct,
  output logic               oZero
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      count_q, count_d;
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    count_d = count_q;
    if (state_q == IDLE && iValid) begin
      state_d = RUN;
      mcand_d = iDataA;
      acc_d   = {{WIDTH{1'b0}}, iDataB};
      count_d = '0;
    end else if (state_q == RUN) begin
      // keep the adder carry as the new MSB so the full-width sum survives the shift
      acc_d   = {iAddCout, iAddSum, acc_q[WIDTH-1:1]};
      count_d = count_q + 1'b1;
      state_d = (count_q == CW'(WIDTH - 1)) ? DONE : RUN;
    end else if (state_q == DONE && iReady) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end
  assign oReady   = (state_q == IDLE);
  assign oValid   = (state_q == DONE);
  assign oProduct = oValid ? acc_q : '0;
  assign oZero    = ~|oProduct;
  assign oAddA    = acc_q[2*WIDTH-1:WIDTH];
  assign oAddB    = acc_q[0] ? mcand_q : '0;
  assign oAddCin  = 1'b0;
endmodule
